// File: rtl/fifo_rptr_empty_if.sv
// Read-side bus of the async FIFO pointer block.
// The reader and write-pointer source drive rinc/wptr. The read block returns address and status.
interface fifo_rptr_empty_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   rlevel;

  modport master (
    output rinc, wptr,
    input  raddr, rptr, rempty, ralmost_empty, rlevel
  );

  modport slave (
    input  rinc, wptr,
    output raddr, rptr, rempty, ralmost_empty, rlevel
  );
endinterface

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer and status block of the async FIFO.
// It brings the Gray write pointer into rclk through a two-flop synchroniser.
// It keeps the binary and Gray read pointers.
// It produces registered empty, almost-empty and fill-level flags.
// The flags are pessimistic because they use the delayed write pointer.
module fifo_rptr_empty #(
  parameter int ADDRSIZE     = 4,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              rclk,
  input  logic              rrst,
  fifo_rptr_empty_if.slave  bus
);

  localparam logic [ADDRSIZE:0] AE_THR = ALMOST_EMPTY[ADDRSIZE:0];

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] r_rq1_wptr;
  logic [ADDRSIZE:0] r_rq2_wptr;
  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic              r_rempty;
  logic              r_ralmost_empty;
  logic [ADDRSIZE:0] r_rlevel;

  logic              w_pop;
  logic [ADDRSIZE:0] w_rbinnext;
  logic [ADDRSIZE:0] w_rgraynext;
  logic [ADDRSIZE:0] w_rwbin;
  logic [ADDRSIZE:0] w_level_next;

  // A pop is only honoured while the FIFO is not empty, so underflow is impossible.
  assign w_pop        = bus.rinc & ~r_rempty;
  assign w_rbinnext   = r_rbin + {{ADDRSIZE{1'b0}}, w_pop};
  assign w_rgraynext  = bin2gray(w_rbinnext);
  // The synchronised write pointer is converted to binary for the level arithmetic only.
  assign w_rwbin      = gray2bin(r_rq2_wptr);
  assign w_level_next = w_rwbin - w_rbinnext;

  // Two-flop synchroniser for the Gray write pointer, with no logic between the stages.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rq1_wptr <= '0;
      r_rq2_wptr <= '0;
    end else begin
      r_rq1_wptr <= bus.wptr;
      r_rq2_wptr <= r_rq1_wptr;
    end
  end

  // Pointer advance and status registers.
  // Status is computed from the next read pointer, so empty asserts on the edge that pops the last entry.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rbin          <= '0;
      r_rptr          <= '0;
      r_rempty        <= 1'b1;
      r_ralmost_empty <= 1'b1;
      r_rlevel        <= '0;
    end else begin
      r_rbin          <= w_rbinnext;
      r_rptr          <= w_rgraynext;
      r_rempty        <= (w_rgraynext == r_rq2_wptr);
      r_rlevel        <= w_level_next;
      r_ralmost_empty <= (w_level_next <= AE_THR);
    end
  end

  assign bus.raddr         = r_rbin[ADDRSIZE-1:0];
  assign bus.rptr          = r_rptr;
  assign bus.rempty        = r_rempty;
  assign bus.ralmost_empty = r_ralmost_empty;
  assign bus.rlevel        = r_rlevel;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Bench for the read-side pointer and status block of the async FIFO.
// The reference model counts entries written and read as plain integers.
// It delays the write count by two rclk edges to stand in for the synchroniser.
module tb_fifo_rptr_empty;
  localparam int AW = 4;
  localparam int AE = 2;
  localparam int PM = 1 << (AW + 1);   // pointer modulus
  localparam int DEPTH = 1 << AW;

  logic rclk = 1'b0;
  logic rrst = 1'b0;

  fifo_rptr_empty_if #(.ADDRSIZE(AW)) bus ();

  fifo_rptr_empty #(.ADDRSIZE(AW), .ALMOST_EMPTY(AE)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: total write count and read count (mod PM), plus a two-edge delay of the write count.
  int wcnt, m_rd, m_s1, m_s2, m_level;
  bit m_empty, m_ae;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & (PM - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".raddr"},  32'(bus.raddr),         32'(m_rd % DEPTH));
    chk({tag, ".rptr"},   32'(bus.rptr),          32'(gray(m_rd)));
    chk({tag, ".rempty"}, 32'(bus.rempty),        32'(m_empty));
    chk({tag, ".ralmost"},32'(bus.ralmost_empty), 32'(m_ae));
    chk({tag, ".rlevel"}, 32'(bus.rlevel),        32'(m_level));
  endtask

  task automatic model_reset();
    m_rd = 0; m_s1 = 0; m_s2 = 0;
    m_level = 0; m_empty = 1'b1; m_ae = 1'b1;
  endtask

  // One rclk edge with the given read request.
  // The model uses the write count as it stood two edges earlier.
  task automatic step(input string tag, input bit inc);
    int nxt, lvl;
    bus.rinc = inc;
    bus.wptr = (AW+1)'(gray(wcnt));
    @(posedge rclk);
    nxt     = (m_rd + ((inc && !m_empty) ? 1 : 0)) % PM;
    lvl     = (m_s2 - nxt + PM) % PM;
    m_rd    = nxt;
    m_level = lvl;
    m_empty = (lvl == 0);
    m_ae    = (lvl <= AE);
    m_s2    = m_s1;
    m_s1    = wcnt;
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse between edges.
  // The outputs are checked before any clock edge arrives.
  task automatic do_reset(input int w);
    wcnt     = w;
    bus.wptr = (AW+1)'(gray(w));
    bus.rinc = 1'b0;
    #2 rrst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    chk("reset.rempty_const", 32'(bus.rempty), 32'd1);
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  initial begin
    wcnt = 0;
    model_reset();
    bus.rinc = 1'b0;
    bus.wptr = '0;

    // Reset with wptr already at gray(5).
    // rempty falls on the 3rd edge after release.
    do_reset(5);
    step("rst_sync1", 1'b0);
    step("rst_sync2", 1'b0);
    step("rst_sync3", 1'b0);
    chk("rst_sync.rempty_low", 32'(bus.rempty), 32'd0);

    // Single write from reset.
    do_reset(0);
    wcnt = 1;
    for (int i = 0; i < 4; i++) step("single", 1'b0);
    chk("single.rlevel", 32'(bus.rlevel), 32'd1);

    // Drain five entries with seven pops.
    // The last two pops are ignored.
    do_reset(5);
    for (int i = 0; i < 3; i++) step("drain_sync", 1'b0);
    for (int i = 0; i < 7; i++) step("drain", 1'b1);
    chk("drain.raddr_hold", 32'(bus.raddr), 32'd5);
    chk("drain.rptr_hold",  32'(bus.rptr),  32'b00111);

    // Asynchronous reset in the middle of a drain, after three pops.
    do_reset(5);
    for (int i = 0; i < 3; i++) step("mid_sync", 1'b0);
    for (int i = 0; i < 3; i++) step("mid_pop", 1'b1);
    do_reset(5);
    for (int i = 0; i < 3; i++) step("mid_resync", 1'b0);
    for (int i = 0; i < 2; i++) step("mid_restart", 1'b1);

    // Full level, then drain across the pointer wrap.
    do_reset(16);
    for (int i = 0; i < 3; i++) step("full_sync", 1'b0);
    chk("full.rlevel", 32'(bus.rlevel), 32'd16);
    for (int i = 0; i < 20; i++) step("wrap_drain", 1'b1);
    chk("wrap.rptr", 32'(bus.rptr), 32'b11000);
    wcnt = 20;
    for (int i = 0; i < 3; i++) step("wrap_sync", 1'b0);
    for (int i = 0; i < 5; i++) step("wrap_pop", 1'b1);

    // Random writes and reads, keeping occupancy within depth.
    // The pointers wrap several times.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && ((wcnt - m_rd + PM) % PM) < DEPTH)
        wcnt = (wcnt + 1) % PM;
      step("random", 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
